// File: rtl/gc_mem_sched_if.sv
// Signal bundle for gc_mem_sched: client requests and returns, both memory ports,
// and the clear handshake. The scheduler takes the slave side.
interface gc_mem_sched_if #(
   parameter int S = 20,
   parameter int K = 128,
   parameter int N = 4
);
   logic [N-1:0]   c_req;
   logic [N-1:0]   c_we;
   logic [N*S-1:0] c_addr;
   logic [N*K-1:0] c_wdata;
   logic [N-1:0]   c_gnt;
   logic [N-1:0]   c_rvalid;
   logic [N-1:0]   c_rmiss;
   logic [N*K-1:0] c_rdata;
   logic           clr_req;
   logic           clr_done;
   logic           mem_wr_en_0;
   logic           mem_wr_en_1;
   logic [S-1:0]   mem_wr_addr_0;
   logic [S-1:0]   mem_wr_addr_1;
   logic [S-1:0]   mem_rd_addr_0;
   logic [S-1:0]   mem_rd_addr_1;
   logic [K-1:0]   mem_wr_data_0;
   logic [K-1:0]   mem_wr_data_1;
   logic           mem_clr;
   logic           mem_rd_ready_0;
   logic           mem_rd_ready_1;
   logic [K-1:0]   mem_rd_data_0;
   logic [K-1:0]   mem_rd_data_1;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, clr_req,
             mem_rd_ready_0, mem_rd_ready_1, mem_rd_data_0, mem_rd_data_1,
      output c_gnt, c_rvalid, c_rmiss, c_rdata, clr_done,
             mem_wr_en_0, mem_wr_en_1, mem_wr_addr_0, mem_wr_addr_1,
             mem_rd_addr_0, mem_rd_addr_1, mem_wr_data_0, mem_wr_data_1, mem_clr
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, clr_req,
             mem_rd_ready_0, mem_rd_ready_1, mem_rd_data_0, mem_rd_data_1,
      input  c_gnt, c_rvalid, c_rmiss, c_rdata, clr_done,
             mem_wr_en_0, mem_wr_en_1, mem_wr_addr_0, mem_wr_addr_1,
             mem_rd_addr_0, mem_rd_addr_1, mem_wr_data_0, mem_wr_data_1, mem_clr
   );
endinterface

// File: rtl/gc_mem_sched.sv
// Label-memory scheduler: round-robin grants of up to two client requests per cycle onto
// two memory ports, tagged read returns after RD_LAT cycles, and a drain-then-clear sequence.
module gc_mem_sched #(
   parameter int S      = 20,
   parameter int K      = 128,
   parameter int N      = 4,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   gc_mem_sched_if.slave bus
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

   // The port half of the return tag is the slot index in the pipeline.
   typedef struct packed {
      logic          vld;
      logic          miss;
      logic [CW-1:0] client;
   } tag_t;

   state_t        state_q, state_d;
   logic [CW-1:0] rr_q, rr_d;
   logic          clr_done_q, clr_done_d;
   tag_t [1:0]    pipe_q [RD_LAT];
   tag_t [1:0]    pipe_d [RD_LAT];

   logic [S-1:0]  addr_c  [N];
   logic [K-1:0]  wdata_c [N];
   logic [N-1:0]  busy;
   logic          any_pending;
   logic [N-1:0]  gnt;
   logic [1:0]    slot_vld;
   logic [1:0]    slot_we;
   logic [CW-1:0] slot_cl [2];
   logic [1:0]    rd_ready;
   logic [K-1:0]  rd_data [2];
   logic [1:0]    mwr_en;
   logic [S-1:0]  mwr_addr [2];
   logic [S-1:0]  mrd_addr [2];
   logic [K-1:0]  mwr_data [2];

   assign rd_ready   = {bus.mem_rd_ready_1, bus.mem_rd_ready_0};
   assign rd_data[0] = bus.mem_rd_data_0;
   assign rd_data[1] = bus.mem_rd_data_1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         addr_c[i]  = bus.c_addr[i*S +: S];
         wdata_c[i] = bus.c_wdata[i*K +: K];
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      busy        = '0;
      any_pending = 1'b0;
      for (int s = 0; s < RD_LAT; s++) begin
         for (int p = 0; p < 2; p++) begin
            if (pipe_q[s][p].vld) begin
               busy[pipe_q[s][p].client] = 1'b1;
               any_pending               = 1'b1;
            end
         end
      end
   end

   // Arbiter: scan from rr; a second candidate that collides with the first ends the scan.
   always_comb begin
      int            c;
      int            last;
      logic [CW-1:0] ci;
      logic [CW-1:0] fi;
      logic          stop;
      logic          allow;
      gnt        = '0;
      slot_vld   = '0;
      slot_we    = '0;
      slot_cl[0] = '0;
      slot_cl[1] = '0;
      rr_d       = rr_q;
      c          = 0;
      last       = 0;
      ci         = '0;
      fi         = '0;
      stop       = 1'b0;
      allow      = rst && (state_q == RUN) && !bus.clr_req;
      for (int i = 0; i < N; i++) begin
         c  = int'(rr_q) + i;
         if (c >= N) c = c - N;
         ci = CW'(c);
         if (allow && !stop && !slot_vld[1] && bus.c_req[ci] && (bus.c_we[ci] || !busy[ci])) begin
            if (!slot_vld[0]) begin
               slot_vld[0] = 1'b1;
               slot_we[0]  = bus.c_we[ci];
               slot_cl[0]  = ci;
               fi          = ci;
               gnt[ci]     = 1'b1;
               last        = c;
            end else if (addr_c[ci] == addr_c[fi] && (bus.c_we[ci] || bus.c_we[fi])) begin
               stop = 1'b1;
            end else begin
               slot_vld[1] = 1'b1;
               slot_we[1]  = bus.c_we[ci];
               slot_cl[1]  = ci;
               gnt[ci]     = 1'b1;
               last        = c;
            end
         end
      end
      if (slot_vld[0]) rr_d = CW'((last + 1) % N);
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         mwr_en[p]   = 1'b0;
         mwr_addr[p] = '0;
         mrd_addr[p] = '0;
         mwr_data[p] = '0;
         if (slot_vld[p]) begin
            if (slot_we[p]) begin
               mwr_en[p]   = 1'b1;
               mwr_addr[p] = addr_c[slot_cl[p]];
               mwr_data[p] = wdata_c[slot_cl[p]];
            end else begin
               mrd_addr[p] = addr_c[slot_cl[p]];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         pipe_d[0][p].vld    = slot_vld[p] && !slot_we[p];
         pipe_d[0][p].miss   = !rd_ready[p];
         pipe_d[0][p].client = slot_cl[p];
      end
      for (int s = 1; s < RD_LAT; s++) pipe_d[s] = pipe_q[s-1];
   end

   always_comb begin
      logic [N-1:0] rv;
      logic [N-1:0] rm;
      logic [K-1:0] rdat [N];
      rv = '0;
      rm = '0;
      for (int i = 0; i < N; i++) rdat[i] = '0;
      for (int p = 0; p < 2; p++) begin
         if (rst && pipe_q[RD_LAT-1][p].vld) begin
            rv[pipe_q[RD_LAT-1][p].client]   = 1'b1;
            rm[pipe_q[RD_LAT-1][p].client]   = pipe_q[RD_LAT-1][p].miss;
            rdat[pipe_q[RD_LAT-1][p].client] = rd_data[p];
         end
      end
      bus.c_rvalid = rv;
      bus.c_rmiss  = rm;
      bus.c_rdata  = '0;
      for (int i = 0; i < N; i++) bus.c_rdata[i*K +: K] = rdat[i];
   end

   always_comb begin
      state_d    = state_q;
      clr_done_d = 1'b0;
      case (state_q)
         RUN:     if (bus.clr_req) state_d = DRAIN;
         DRAIN:   if (!any_pending) state_d = CLEAR;
         CLEAR: begin
            state_d    = RUN;
            clr_done_d = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= RUN;
         rr_q       <= '0;
         clr_done_q <= 1'b0;
         for (int s = 0; s < RD_LAT; s++) pipe_q[s] <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         clr_done_q <= clr_done_d;
         for (int s = 0; s < RD_LAT; s++) pipe_q[s] <= pipe_d[s];
      end
   end

   assign bus.c_gnt         = gnt;
   assign bus.mem_wr_en_0   = mwr_en[0];
   assign bus.mem_wr_en_1   = mwr_en[1];
   assign bus.mem_wr_addr_0 = mwr_addr[0];
   assign bus.mem_wr_addr_1 = mwr_addr[1];
   assign bus.mem_rd_addr_0 = mrd_addr[0];
   assign bus.mem_rd_addr_1 = mrd_addr[1];
   assign bus.mem_wr_data_0 = mwr_data[0];
   assign bus.mem_wr_data_1 = mwr_data[1];
   assign bus.mem_clr       = rst && (state_q == CLEAR);
   assign bus.clr_done      = clr_done_q;

endmodule
